// File: rtl/jtkunio_pkg.sv
// Shared types for the Kunio object DMA path.
// State encoding and default object buffer width.
package jtkunio_pkg;

    localparam int OBJ_AW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } dma_st_e;

endpackage

// File: rtl/jtkunio_objdma.sv
// Object RAM DMA sequencer: takes the CPU bus, copies 2**AW bytes
// from sprite attribute RAM into the object buffer, then gives it back.
module jtkunio_objdma
    import jtkunio_pkg::*;
#(
    parameter int            AW   = OBJ_AW,
    parameter logic [AW-1:0] SRC0 = '0
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          busak_n,
    output logic          busrq,
    output logic [AW-1:0] src_addr,
    input  logic [7:0]    src_data,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          buf_we,
    output logic          busy
);

    localparam logic [AW-1:0] LAST = '1;
    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

    dma_st_e       state_q, state_d;
    logic          go_l_q, go_l_d;
    logic          pend_q, pend_d;
    logic          busrq_q, busrq_d;
    logic          busy_q, busy_d;
    logic          rdv_q, rdv_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [7:0]    bdin_q, bdin_d;
    logic          bwe_q, bwe_d;

    logic          edge_w;
    logic [AW-1:0] nxt_w;

    assign edge_w = dma_go & ~go_l_q;
    assign nxt_w  = cnt_q + ONE;

    // State and datapath registers; reset drops the bus request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            go_l_q  <= 1'b0;
            pend_q  <= 1'b0;
            busrq_q <= 1'b0;
            busy_q  <= 1'b0;
            rdv_q   <= 1'b0;
            cnt_q   <= '0;
            src_q   <= SRC0;
            baddr_q <= '0;
            bdin_q  <= '0;
            bwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            go_l_q  <= go_l_d;
            pend_q  <= pend_d;
            busrq_q <= busrq_d;
            busy_q  <= busy_d;
            rdv_q   <= rdv_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            baddr_q <= baddr_d;
            bdin_q  <= bdin_d;
            bwe_q   <= bwe_d;
        end
    end

    // Bus handshake, read pipeline (address now, write next cen) and trigger queue.
    always_comb begin
        state_d = state_q;
        go_l_d  = go_l_q;
        pend_d  = pend_q;
        busrq_d = busrq_q;
        busy_d  = busy_q;
        rdv_d   = rdv_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        baddr_d = baddr_q;
        bdin_d  = bdin_q;
        bwe_d   = bwe_q;
        if (cen) begin
            go_l_d = dma_go;
            bwe_d  = 1'b0;
            if (edge_w && busy_q) pend_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (edge_w || pend_q) begin
                        if (!edge_w) pend_d = 1'b0;
                        state_d = REQ;
                        busrq_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        state_d = XFER;
                        cnt_d   = '0;
                        rdv_d   = 1'b1;
                        src_d   = SRC0;
                    end
                end
                XFER: begin
                    if (!busak_n) begin
                        if (rdv_q) begin
                            bwe_d   = 1'b1;
                            baddr_d = cnt_q;
                            bdin_d  = src_data;
                            if (cnt_q == LAST) begin
                                rdv_d = 1'b0;
                            end else begin
                                cnt_d = nxt_w;
                                src_d = SRC0 + nxt_w;
                            end
                        end else begin
                            state_d = REL;
                            busrq_d = 1'b0;
                        end
                    end
                end
                REL: begin
                    if (busak_n) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busrq    = busrq_q;
    assign busy     = busy_q;
    assign src_addr = src_q;
    assign buf_addr = baddr_q;
    assign buf_din  = bdin_q;
    assign buf_we   = bwe_q;

endmodule

// File: tb/tb_jtkunio_objdma.sv
// Bench for jtkunio_objdma: two 16-byte instances, one starting at
// source offset 0 and one at 0xE, sharing control and bus acknowledge.
module tb_jtkunio_objdma;

    localparam int LEN  = 16;
    localparam int WOFS = 14;

    logic       clk = 1'b0;
    logic       rst_n, cen, dma_go, busak_n;
    logic       busrq0, busy0, buf_we0;
    logic [3:0] src_addr0, buf_addr0;
    logic [7:0] buf_din0, src_data0;
    logic       busrqw, busyw, buf_wew;
    logic [3:0] src_addrw, buf_addrw;
    logic [7:0] buf_dinw, src_dataw;
    logic [7:0] src_mem [LEN];

    assign src_data0 = src_mem[src_addr0];
    assign src_dataw = src_mem[src_addrw];

    jtkunio_objdma #(.AW(4), .SRC0(4'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go),
        .busak_n(busak_n), .busrq(busrq0), .src_addr(src_addr0),
        .src_data(src_data0), .buf_addr(buf_addr0), .buf_din(buf_din0),
        .buf_we(buf_we0), .busy(busy0)
    );

    jtkunio_objdma #(.AW(4), .SRC0(4'hE)) dutw (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go),
        .busak_n(busak_n), .busrq(busrqw), .src_addr(src_addrw),
        .src_data(src_dataw), .buf_addr(buf_addrw), .buf_din(buf_dinw),
        .buf_we(buf_wew), .busy(busyw)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit c, go, ak_n;
        bit rq, by, we;
        int sa, wa;
    } vec_t;

    vec_t        tbl [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cen_mode = 3;
    int          clk_n = 0;
    bit          auto_ak = 1'b0;
    bit          stall = 1'b0;
    bit          rnd_stall = 1'b0;
    bit          rst_evt = 1'b0;
    bit          have_prev = 1'b0;
    logic [2:0]  ak_hist = '0;
    logic [37:0] prev_snap = '0;
    logic [11:0] obs0 [$];
    logic [11:0] obsw [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] snap();
        return {busrq0, busy0, buf_we0, src_addr0, buf_addr0, buf_din0,
                busrqw, busyw, buf_wew, src_addrw, buf_addrw, buf_dinw};
    endfunction

    // expected byte at buffer slot k for an instance whose source starts at ofs
    function automatic logic [7:0] exp_byte(input int ofs, input int k);
        return src_mem[(ofs + k) % LEN];
    endfunction

    task automatic add_v(input bit c, input bit go, input bit ak, input bit rq,
                         input bit by, input bit we, input int sa, input int wa);
        vec_t v;
        v.c = c; v.go = go; v.ak_n = ak;
        v.rq = rq; v.by = by; v.we = we;
        v.sa = sa; v.wa = wa;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(negedge clk);
        if (cen_mode == 0) cen = 1'b1;
        else if (cen_mode == 1) cen = (clk_n % 8 == 0);
        else if (cen_mode == 2) cen = ($urandom_range(0, 2) != 0);
        clk_n++;
        if (rnd_stall) stall = ($urandom_range(0, 4) == 0);
        if (auto_ak) busak_n = stall | ~ak_hist[2];
        @(posedge clk);
        #1;
        if (cen) ak_hist = {ak_hist[1:0], busrq0};
        if (rst_n && !rst_evt) begin
            if (have_prev && !cen) chk("hold_no_cen", snap(), prev_snap);
            if (cen && busak_n) begin
                chk("stall_we0", buf_we0, 0);
                chk("stall_wew", buf_wew, 0);
            end
            if (cen && buf_we0) obs0.push_back({buf_addr0, buf_din0});
            if (cen && buf_wew) obsw.push_back({buf_addrw, buf_dinw});
        end
        rst_evt   = 1'b0;
        prev_snap = snap();
        have_prev = rst_n;
    endtask

    task automatic cen_step();
        int n = 0;
        do begin
            step();
            n++;
        end while (!cen && n < 64);
    endtask

    task automatic pulse_go();
        dma_go = 1'b1;
        cen_step();
        dma_go = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string nm);
        int i = 0;
        while (obs0.size() < n && i < budget) begin
            step();
            i++;
        end
        chk(nm, obs0.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i = 0;
        while ((busy0 || busrq0) && i < budget) begin
            step();
            i++;
        end
        chk(nm, {busy0, busrq0}, 0);
        repeat (100) step();
    endtask

    task automatic check_stream(input int ntr, input string nm);
        chk({nm, "_count0"}, obs0.size(), ntr * LEN);
        chk({nm, "_countw"}, obsw.size(), ntr * LEN);
        for (int i = 0; i < ntr * LEN && i < obs0.size(); i++) begin
            int k = i % LEN;
            chk($sformatf("%s_w0_%0d", nm, i), obs0[i], {k[3:0], exp_byte(0, k)});
        end
        for (int i = 0; i < ntr * LEN && i < obsw.size(); i++) begin
            int k = i % LEN;
            chk($sformatf("%s_ww_%0d", nm, i), obsw[i], {k[3:0], exp_byte(WOFS, k)});
        end
        obs0.delete();
        obsw.delete();
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; dma_go = 1'b0; busak_n = 1'b1;
        foreach (src_mem[a]) src_mem[a] = 8'hA0 + 8'(a);

        // cycle table: cen, go, busak_n -> busrq, busy, buf_we, src index, write addr
        add_v(1, 0, 1, 0, 0, 0, 0, 0);
        add_v(1, 1, 1, 1, 1, 0, 0, 0);
        add_v(0, 0, 1, 1, 1, 0, 0, 0);
        add_v(1, 0, 1, 1, 1, 0, 0, 0);
        add_v(1, 0, 0, 1, 1, 0, 0, 0);
        add_v(1, 0, 0, 1, 1, 1, 1, 0);
        add_v(0, 0, 0, 1, 1, 1, 1, 0);
        add_v(1, 0, 0, 1, 1, 1, 2, 1);
        add_v(1, 0, 1, 1, 1, 0, 2, 0);
        add_v(1, 0, 1, 1, 1, 0, 2, 0);
        add_v(1, 0, 0, 1, 1, 1, 3, 2);
        for (int w = 3; w < 15; w++) add_v(1, 0, 0, 1, 1, 1, w + 1, w);
        add_v(1, 0, 0, 1, 1, 1, 15, 15);
        add_v(1, 0, 0, 0, 1, 0, 15, 0);
        add_v(1, 0, 0, 0, 1, 0, 15, 0);
        add_v(1, 0, 1, 0, 0, 0, 15, 0);
        add_v(1, 0, 1, 0, 0, 0, 15, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busrq", busrq0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_we", buf_we0, 0);
        chk("rst_src0", src_addr0, 4'h0);
        chk("rst_srcw", src_addrw, 4'hE);
        chk("rst_baddr", buf_addr0, 0);
        chk("rst_bdin", buf_din0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            cen = tbl[r].c;
            dma_go = tbl[r].go;
            busak_n = tbl[r].ak_n;
            step();
            chk($sformatf("r%0d_busrq0", r), busrq0, tbl[r].rq);
            chk($sformatf("r%0d_busrqw", r), busrqw, tbl[r].rq);
            chk($sformatf("r%0d_busy", r), busy0, tbl[r].by);
            chk($sformatf("r%0d_we", r), buf_we0, tbl[r].we);
            chk($sformatf("r%0d_src0", r), src_addr0, tbl[r].sa);
            chk($sformatf("r%0d_srcw", r), src_addrw, (WOFS + tbl[r].sa) % LEN);
            if (tbl[r].we) begin
                chk($sformatf("r%0d_baddr0", r), buf_addr0, tbl[r].wa);
                chk($sformatf("r%0d_bdin0", r), buf_din0, exp_byte(0, tbl[r].wa));
                chk($sformatf("r%0d_baddrw", r), buf_addrw, tbl[r].wa);
                chk($sformatf("r%0d_bdinw", r), buf_dinw, exp_byte(WOFS, tbl[r].wa));
            end
        end
        check_stream(1, "table");

        // stall for 5 cen after the 6th write
        cen_mode = 0; auto_ak = 1'b1; ak_hist = '0;
        pulse_go();
        wait_writes(6, 400, "stall_w6");
        stall = 1'b1;
        repeat (5) step();
        chk("stall_frozen", obs0.size(), 6);
        stall = 1'b0;
        wait_writes(LEN, 400, "stall_wr");
        wait_idle(400, "stall_idle");
        check_stream(1, "stall");

        // second edge at write 8 queues one more transfer; third edge is dropped
        pulse_go();
        wait_writes(8, 400, "pend_w8");
        pulse_go();
        wait_writes(11, 400, "pend_w11");
        pulse_go();
        wait_writes(2 * LEN, 800, "pend_wr");
        wait_idle(400, "pend_idle");
        check_stream(2, "pend");

        // edge in the same cen as the release back to idle
        pulse_go();
        wait_writes(LEN, 400, "sim_wr");
        begin
            int n = 0;
            while (busrq0 && n < 100) begin
                step();
                n++;
            end
        end
        chk("sim_rel", busrq0, 0);
        step();
        step();
        dma_go = 1'b1;
        step();
        dma_go = 1'b0;
        wait_writes(2 * LEN, 800, "sim_wr2");
        wait_idle(400, "sim_idle");
        check_stream(2, "simul");

        // reset in the middle of the copy
        pulse_go();
        wait_writes(5, 400, "rst_w5");
        chk("rst_pre_we", buf_we0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busrq0", busrq0, 0);
        chk("mid_rst_busy0", busy0, 0);
        chk("mid_rst_we0", buf_we0, 0);
        chk("mid_rst_busrqw", busrqw, 0);
        chk("mid_rst_wew", buf_wew, 0);
        rst_evt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ak_hist = '0;
        busak_n = 1'b1;
        obs0.delete();
        obsw.delete();
        repeat (80) step();
        chk("rst_no_writes", obs0.size(), 0);
        chk("rst_stay_idle", busy0, 0);

        // cen on every 8th clock
        cen_mode = 1;
        pulse_go();
        wait_writes(LEN, 2000, "cen8_wr");
        wait_idle(2000, "cen8_idle");
        check_stream(1, "cen8");

        // random data, random cen and random bus stalls
        cen_mode = 2;
        for (int t = 0; t < 6; t++) begin
            foreach (src_mem[a]) src_mem[a] = 8'($urandom);
            rnd_stall = 1'b1;
            pulse_go();
            wait_writes(LEN, 3000, $sformatf("rnd%0d_wr", t));
            rnd_stall = 1'b0;
            stall = 1'b0;
            wait_idle(3000, $sformatf("rnd%0d_idle", t));
            check_stream(1, $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
